// File: rtl/conv_window_gen_if.sv
// Pixel-stream interface for conv_window_gen.
//   i_pixel/i_valid/i_sof : raster-order pixel stream into the window generator
//   o_window/o_valid/o_frame_done : 3x3 window stream out to the MAC stage
// master drives the pixel stream and observes the window outputs;
// slave is the window generator itself.
interface conv_window_gen_if #(
  parameter int NB_PIXEL = 8
);
  logic [NB_PIXEL-1:0]   i_pixel;
  logic                  i_valid;
  logic                  i_sof;
  logic [9*NB_PIXEL-1:0] o_window;
  logic                  o_valid;
  logic                  o_frame_done;

  modport master (
    output i_pixel, i_valid, i_sof,
    input  o_window, o_valid, o_frame_done
  );

  modport slave (
    input  i_pixel, i_valid, i_sof,
    output o_window, o_valid, o_frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: two-line buffer plus 3x3 register window for a raster
// pixel stream. Every accepted pixel whose full 3x3 neighbourhood lies inside
// the image produces a valid window one clock later (no border padding).
//   clk      : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : conv_window_gen_if.slave
//     i_pixel/i_valid/i_sof   pixel in, qualifier, start of frame
//     o_window                9 pixels, slice k = 3*wr + wc, k=8 is newest
//     o_valid                 o_window is a complete in-image window
//     o_frame_done            pulse after the last pixel of a frame
module conv_window_gen #(
  parameter int NB_PIXEL   = 8,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  conv_window_gen_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col, col_nxt, eff_col;
  logic [RW-1:0] row, row_nxt, eff_row;
  logic          accept;
  logic          win_in_image;
  logic          frame_last;
  logic          valid_q;
  logic          frame_done_q;

  logic [NB_PIXEL-1:0] lb0 [IMG_WIDTH];
  logic [NB_PIXEL-1:0] lb1 [IMG_WIDTH];
  logic [NB_PIXEL-1:0] win [3][3];

  assign accept = bus.i_valid;

  // Coordinates of the pixel being accepted: i_sof overrides the counters so
  // the current pixel is (0,0) and counting resumes from (0,1).
  always_comb begin
    eff_col = col;
    eff_row = row;
    if (bus.i_sof) begin
      eff_col = '0;
      eff_row = '0;
    end
    col_nxt = eff_col + 1'b1;
    row_nxt = eff_row;
    if (eff_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
    end
    win_in_image = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
    frame_last   = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col          <= '0;
      row          <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned wr = 0; wr < 3; wr++) begin
        for (int unsigned wc = 0; wc < 3; wc++) begin
          win[wr][wc] <= '0;
        end
      end
    end else begin
      valid_q      <= accept && win_in_image;
      frame_done_q <= accept && frame_last;
      if (accept) begin
        col <= col_nxt;
        row <= row_nxt;
        for (int unsigned wr = 0; wr < 3; wr++) begin
          win[wr][0] <= win[wr][1];
          win[wr][1] <= win[wr][2];
        end
        win[0][2] <= lb0[eff_col];
        win[1][2] <= lb1[eff_col];
        win[2][2] <= bus.i_pixel;
      end
    end
  end

  // Line buffers are never read before being rewritten in a new frame's
  // first two rows, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[eff_col] <= bus.i_pixel;
      lb0[eff_col] <= lb1[eff_col];
    end
  end

  always_comb begin
    bus.o_window = '0;
    for (int unsigned wr = 0; wr < 3; wr++) begin
      for (int unsigned wc = 0; wc < 3; wc++) begin
        bus.o_window[NB_PIXEL*(3*wr+wc) +: NB_PIXEL] = win[wr][wc];
      end
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_frame_done = frame_done_q;

endmodule
